// File: rtl/button_event_arbiter_if.sv
// Button event arbiter bus bundle.
// Button pulses and overflow clear in, event stream out.
interface button_event_arbiter_if;
  logic [3:0] BtnPulse;
  logic       EvtReady;
  logic       ClrOvf;
  logic       EvtValid;
  logic [1:0] EvtCode;
  logic [2:0] EvtCount;
  logic       Overflow;

  modport master (
    output BtnPulse,
    output EvtReady,
    output ClrOvf,
    input  EvtValid,
    input  EvtCode,
    input  EvtCount,
    input  Overflow
  );

  modport slave (
    input  BtnPulse,
    input  EvtReady,
    input  ClrOvf,
    output EvtValid,
    output EvtCode,
    output EvtCount,
    output Overflow
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter of four button pulses into an event FIFO.
// Pending bits per button, sticky overflow when a press is lost.
module button_event_arbiter #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  button_event_arbiter_if.slave bus
);

  if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
    $error("DEPTH must be 2 or 4");
  end

  localparam logic [2:0] LP_DEPTH = 3'(DEPTH);
  localparam logic [1:0] LP_LAST  = 2'(DEPTH - 1);

  logic [3:0] r_pend;
  logic [1:0] r_ptr;
  logic [1:0] r_mem [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       r_ovf;

  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic       w_hit;
  logic [1:0] w_sel;
  logic       w_room;
  logic       w_gnt;
  logic [1:0] w_gnt_idx;
  logic [3:0] w_gnt_oh;
  logic [3:0] w_pend_nxt;
  logic       w_lost;
  logic       w_pop;
  logic [1:0] w_wptr_nxt;
  logic [1:0] w_rptr_nxt;

  // Rotate pending bits so index 0 is the round-robin start.
  assign w_dbl = {r_pend, r_pend} >> r_ptr;
  assign w_rot = w_dbl[3:0];

  // First set bit in rotated order, lowest offset wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_hit = 1'b1;
        w_sel = 2'(k);
      end
    end
  end

  assign w_room    = r_count < LP_DEPTH;
  assign w_gnt     = w_hit && w_room;
  assign w_gnt_idx = r_ptr + w_sel;
  assign w_gnt_oh  = w_gnt ? (4'b0001 << w_gnt_idx)
                           : 4'b0000;

  // A press on a granted button survives as a new pending bit.
  assign w_pend_nxt = (r_pend & ~w_gnt_oh)
                    | bus.BtnPulse;
  assign w_lost = |(bus.BtnPulse & r_pend & ~w_gnt_oh);

  assign w_pop = (r_count != 3'd0) && bus.EvtReady;

  assign w_wptr_nxt = (r_wptr == LP_LAST) ? 2'd0
                                          : r_wptr + 2'd1;
  assign w_rptr_nxt = (r_rptr == LP_LAST) ? 2'd0
                                          : r_rptr + 2'd1;

  // Pending bits and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 4'd0;
      r_ptr  <= 2'd0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_gnt) begin
        r_ptr <= w_gnt_idx + 2'd1;
      end
    end
  end

  // FIFO storage and tail pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 2'd0;
      end
      r_wptr <= 2'd0;
    end else if (w_gnt) begin
      r_mem[r_wptr] <= w_gnt_idx;
      r_wptr        <= w_wptr_nxt;
    end
  end

  // FIFO head pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr <= 2'd0;
    end else if (w_pop) begin
      r_rptr <= w_rptr_nxt;
    end
  end

  // Occupancy: push and pop together leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 3'd0;
    end else begin
      unique case ({w_gnt, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a loss in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_lost) begin
      r_ovf <= 1'b1;
    end else if (bus.ClrOvf) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.EvtValid = r_count != 3'd0;
  assign bus.EvtCode  = r_mem[r_rptr];
  assign bus.EvtCount = r_count;
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for the button event arbiter.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_button_event_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  button_event_arbiter_if bus ();

  button_event_arbiter #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.BtnPulse = 4'b0000;
    bus.EvtReady = 1'b0;
    bus.ClrOvf   = 1'b0;
    #2;
    chk("rst_valid", int'(bus.EvtValid), 0);
    chk("rst_count", int'(bus.EvtCount), 0);
    chk("rst_code",  int'(bus.EvtCode),  0);
    chk("rst_ovf",   int'(bus.Overflow), 0);
    tick;
    rst = 1'b1;
    tick;
    tick;

    // single press on button 2, ready held high
    bus.EvtReady = 1'b1;
    bus.BtnPulse = 4'b0100;
    chk("idle_ready_cnt", int'(bus.EvtCount), 0);
    tick;
    bus.BtnPulse = 4'b0000;
    chk("single_n1_valid", int'(bus.EvtValid), 0);
    tick;
    chk("single_n2_valid", int'(bus.EvtValid), 1);
    chk("single_n2_code",  int'(bus.EvtCode),  2);
    chk("single_n2_cnt",   int'(bus.EvtCount), 1);
    tick;
    chk("single_n3_valid", int'(bus.EvtValid), 0);
    chk("single_n3_cnt",   int'(bus.EvtCount), 0);

    // pointer at 3: 0 and 3 together give 3 first
    bus.BtnPulse = 4'b1001;
    tick;
    bus.BtnPulse = 4'b0000;
    chk("rr3_m1_valid", int'(bus.EvtValid), 0);
    tick;
    chk("rr3_m2_code", int'(bus.EvtCode), 3);
    tick;
    chk("rr3_m3_code", int'(bus.EvtCode), 0);
    chk("rr3_m3_cnt",  int'(bus.EvtCount), 1);
    tick;
    chk("rr3_m4_cnt", int'(bus.EvtCount), 0);

    // grant 3 alone, then 0 and 3 together give 0 first
    bus.BtnPulse = 4'b1000;
    tick;
    bus.BtnPulse = 4'b0000;
    tick;
    chk("rr0_pre_code", int'(bus.EvtCode), 3);
    tick;
    chk("rr0_pre_cnt", int'(bus.EvtCount), 0);
    bus.BtnPulse = 4'b1001;
    tick;
    bus.BtnPulse = 4'b0000;
    tick;
    chk("rr0_first", int'(bus.EvtCode), 0);
    tick;
    chk("rr0_second", int'(bus.EvtCode), 3);
    tick;
    chk("rr0_empty", int'(bus.EvtValid), 0);

    // all four at once straight after a reset
    rst = 1'b0;
    tick;
    rst = 1'b1;
    bus.BtnPulse = 4'b1111;
    tick;
    bus.BtnPulse = 4'b0000;
    tick;
    chk("all_c0", int'(bus.EvtCode), 0);
    chk("all_cnt0", int'(bus.EvtCount), 1);
    tick;
    chk("all_c1", int'(bus.EvtCode), 1);
    chk("all_cnt1", int'(bus.EvtCount), 1);
    tick;
    chk("all_c2", int'(bus.EvtCode), 2);
    tick;
    chk("all_c3", int'(bus.EvtCode), 3);
    tick;
    chk("all_empty", int'(bus.EvtValid), 0);
    chk("all_ovf", int'(bus.Overflow), 0);

    // fill the FIFO with ready low
    bus.EvtReady = 1'b0;
    bus.BtnPulse = 4'b1111;
    tick;
    bus.BtnPulse = 4'b0000;
    tick;
    tick;
    tick;
    tick;
    chk("full_cnt", int'(bus.EvtCount), 4);
    bus.BtnPulse = 4'b0001;
    tick;
    chk("full_hold_cnt", int'(bus.EvtCount), 4);
    chk("full_hold_code", int'(bus.EvtCode), 0);
    chk("full_hold_ovf", int'(bus.Overflow), 0);
    tick;
    bus.BtnPulse = 4'b0000;
    chk("full_lost_ovf", int'(bus.Overflow), 1);
    chk("full_lost_cnt", int'(bus.EvtCount), 4);
    chk("drain_c0", int'(bus.EvtCode), 0);
    bus.EvtReady = 1'b1;
    tick;
    chk("drain_c1", int'(bus.EvtCode), 1);
    chk("drain_cnt1", int'(bus.EvtCount), 3);
    tick;
    chk("drain_c2", int'(bus.EvtCode), 2);
    chk("drain_cnt2", int'(bus.EvtCount), 3);
    tick;
    chk("drain_c3", int'(bus.EvtCode), 3);
    chk("drain_cnt3", int'(bus.EvtCount), 2);
    tick;
    chk("drain_c4", int'(bus.EvtCode), 0);
    chk("drain_cnt4", int'(bus.EvtCount), 1);
    tick;
    chk("drain_empty", int'(bus.EvtValid), 0);
    chk("drain_ovf", int'(bus.Overflow), 1);

    // overflow clear, then clear racing a lost press
    bus.EvtReady = 1'b0;
    bus.ClrOvf   = 1'b1;
    bus.BtnPulse = 4'b1111;
    tick;
    chk("clr_ovf", int'(bus.Overflow), 0);
    bus.BtnPulse = 4'b0110;
    tick;
    bus.BtnPulse = 4'b0000;
    bus.ClrOvf   = 1'b0;
    chk("clr_race_ovf", int'(bus.Overflow), 1);
    chk("clr_race_cnt", int'(bus.EvtCount), 1);
    chk("clr_race_code", int'(bus.EvtCode), 1);
    tick;
    chk("q_cnt2", int'(bus.EvtCount), 2);
    tick;
    chk("q_cnt3", int'(bus.EvtCount), 3);

    // asynchronous reset between edges
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", int'(bus.EvtValid), 0);
    chk("arst_cnt",   int'(bus.EvtCount), 0);
    chk("arst_code",  int'(bus.EvtCode),  0);
    chk("arst_ovf",   int'(bus.Overflow), 0);
    tick;
    rst = 1'b1;
    bus.EvtReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_rst_valid", int'(bus.EvtValid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
